// File: rtl/sensor_hub_core.sv
// Command/response controller serving a bank of DHT11 channels over a byte UART:
// per-channel addressing, continuous polling, sensor/inter-byte watchdogs, one pending request.
module sensor_hub_core #(
    parameter int NUM_SENSORS    = 8,
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int POLL_CYCLES    = 100_000_000
) (
    input  logic                   i_Clock,
    input  logic                   rst_n,
    input  logic [7:0]             i_Rx_Data,
    input  logic                   i_Rx_Done,
    input  logic                   i_Tx_Done,
    output logic [7:0]             o_Tx_Data,
    output logic                   o_Tx_Start,
    input  logic [31:0]            i_Dth_Data,
    input  logic                   i_Dth_Done,
    input  logic                   i_Dth_Error,
    output logic [NUM_SENSORS-1:0] o_Dth_Start,
    output logic [ADDR_W-1:0]      o_Dth_Sel,
    output logic                   o_Busy,
    output logic                   o_Overrun
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_CYCLES);
    localparam logic [1:0] K_TEMP = 2'd0;
    localparam logic [1:0] K_HUM  = 2'd1;
    localparam logic [1:0] K_STAT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_GET_ADDR    = 4'd1,
        S_DECODE      = 4'd2,
        S_MEASURE     = 4'd3,
        S_WAIT_SENSOR = 4'd4,
        S_SEND0       = 4'd5,
        S_WAIT_TX0    = 4'd6,
        S_SEND1       = 4'd7,
        S_WAIT_TX1    = 4'd8
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cmd, r_addr, r_resp1, r_tx_data;
    logic [7:0]            r_pend0, r_pend1, r_res_temp, r_res_hum;
    logic [1:0]            r_pend_cnt, r_meas_kind;
    logic                  r_tx_start, r_busy, r_overrun;
    logic                  r_cont, r_cont_hum, r_res_done, r_res_err;
    logic [ADDR_W-1:0]     r_cont_addr, r_dth_sel;
    logic [NUM_SENSORS-1:0] r_dth_start;
    logic [TW-1:0]         r_wd_cnt;
    logic [PW-1:0]         r_poll_cnt;

    logic                  w_addr_bad, w_wd_exp, w_poll_due, w_unused;
    logic [ADDR_W-1:0]     w_addr_sel;

    function automatic logic [NUM_SENSORS-1:0] onehot(input logic [ADDR_W-1:0] sel);
        logic [NUM_SENSORS-1:0] v;
        for (int i = 0; i < NUM_SENSORS; i++) v[i] = (sel == ADDR_W'(i));
        return v;
    endfunction

    function automatic logic [1:0] meas_kind(input logic [7:0] cmd);
        case (cmd)
            8'h01, 8'h04: return K_TEMP;
            8'h02, 8'h05: return K_HUM;
            default:      return K_STAT;
        endcase
    endfunction

    assign w_addr_bad = ({24'd0, r_addr} >= 32'(NUM_SENSORS));
    assign w_addr_sel = ADDR_W'(r_addr);
    assign w_wd_exp   = (r_wd_cnt >= TO_LIM);
    assign w_poll_due = r_cont && (r_poll_cnt >= POLL_LIM);
    // Decimal bytes of the sensor frame are not reported by any command.
    assign w_unused   = ^{i_Dth_Data[23:16], i_Dth_Data[7:0]};

    assign o_Tx_Data   = r_tx_data;
    assign o_Tx_Start  = r_tx_start;
    assign o_Dth_Start = r_dth_start;
    assign o_Dth_Sel   = r_dth_sel;
    assign o_Busy      = r_busy;
    assign o_Overrun   = r_overrun;

    // Sensor results are registered and accepted only while a measurement is outstanding; error wins.
    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            r_res_done <= 1'b0;
            r_res_err  <= 1'b0;
            r_res_temp <= 8'd0;
            r_res_hum  <= 8'd0;
        end else begin
            r_res_done <= (r_state == S_WAIT_SENSOR) && i_Dth_Done && !i_Dth_Error;
            r_res_err  <= (r_state == S_WAIT_SENSOR) && i_Dth_Error;
            r_res_temp <= i_Dth_Data[15:8];
            r_res_hum  <= i_Dth_Data[31:24];
        end
    end

    // Control FSM: request intake, pending slot, dispatch, watchdogs, polling and response sequencing.
    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'd0;
            r_addr      <= 8'd0;
            r_resp1     <= 8'd0;
            r_tx_data   <= 8'd0;
            r_tx_start  <= 1'b0;
            r_pend0     <= 8'd0;
            r_pend1     <= 8'd0;
            r_pend_cnt  <= 2'd0;
            r_meas_kind <= K_TEMP;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_cont      <= 1'b0;
            r_cont_hum  <= 1'b0;
            r_cont_addr <= '0;
            r_dth_sel   <= '0;
            r_dth_start <= '0;
            r_wd_cnt    <= '0;
            r_poll_cnt  <= '0;
        end else begin
            r_tx_start  <= 1'b0;
            r_dth_start <= '0;
            r_wd_cnt    <= '0;
            if (!r_cont)
                r_poll_cnt <= '0;
            else if (!w_poll_due)
                r_poll_cnt <= r_poll_cnt + 1'b1;

            if (r_busy && i_Rx_Done) begin
                if (r_pend_cnt == 2'd0) begin
                    r_pend0    <= i_Rx_Data;
                    r_pend_cnt <= 2'd1;
                end else if (r_pend_cnt == 2'd1) begin
                    r_pend1    <= i_Rx_Data;
                    r_pend_cnt <= 2'd2;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_cnt == 2'd2) begin
                        r_cmd   <= r_pend0;
                        r_addr  <= r_pend1;
                        r_state <= S_DECODE;
                        r_busy  <= 1'b1;
                        // A byte landing as the slot drains becomes the next pending command.
                        if (i_Rx_Done) begin
                            r_pend0    <= i_Rx_Data;
                            r_pend_cnt <= 2'd1;
                        end else begin
                            r_pend_cnt <= 2'd0;
                        end
                    end else if (r_pend_cnt == 2'd1) begin
                        r_cmd      <= r_pend0;
                        r_pend_cnt <= 2'd0;
                        if (i_Rx_Done) begin
                            r_addr  <= i_Rx_Data;
                            r_state <= S_DECODE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_GET_ADDR;
                        end
                    end else if (i_Rx_Done) begin
                        r_cmd   <= i_Rx_Data;
                        r_state <= S_GET_ADDR;
                    end else if (w_poll_due) begin
                        r_meas_kind <= r_cont_hum ? K_HUM : K_TEMP;
                        r_dth_sel   <= r_cont_addr;
                        r_dth_start <= onehot(r_cont_addr);
                        r_poll_cnt  <= '0;
                        r_state     <= S_MEASURE;
                        r_busy      <= 1'b1;
                    end
                end
                S_GET_ADDR: begin
                    if (i_Rx_Done) begin
                        r_addr  <= i_Rx_Data;
                        r_state <= S_DECODE;
                        r_busy  <= 1'b1;
                    end else if (w_wd_exp) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_state    <= S_SEND0;
                    r_tx_start <= 1'b1;
                    if (r_cmd == 8'h06) begin
                        r_cont    <= 1'b0;
                        r_tx_data <= 8'h0A;
                        r_resp1   <= 8'h00;
                    end else if (r_cmd >= 8'h01 && r_cmd <= 8'h05) begin
                        if (w_addr_bad) begin
                            r_tx_data <= 8'hEE;
                            r_resp1   <= r_addr;
                        end else begin
                            r_tx_start  <= 1'b0;
                            r_state     <= S_MEASURE;
                            r_meas_kind <= meas_kind(r_cmd);
                            r_dth_sel   <= w_addr_sel;
                            r_dth_start <= onehot(w_addr_sel);
                            if (r_cmd == 8'h04 || r_cmd == 8'h05) begin
                                r_cont      <= 1'b1;
                                r_cont_hum  <= (r_cmd == 8'h05);
                                r_cont_addr <= w_addr_sel;
                                r_poll_cnt  <= '0;
                            end
                        end
                    end else begin
                        r_tx_data <= 8'hCF;
                        r_resp1   <= r_cmd;
                    end
                end
                S_MEASURE: r_state <= S_WAIT_SENSOR;
                S_WAIT_SENSOR: begin
                    if (r_res_err || w_wd_exp) begin
                        r_tx_data  <= 8'h1F;
                        r_resp1    <= 8'h00;
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND0;
                    end else if (r_res_done) begin
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND0;
                        case (r_meas_kind)
                            K_TEMP: begin r_tx_data <= 8'h09; r_resp1 <= r_res_temp; end
                            K_HUM:  begin r_tx_data <= 8'h08; r_resp1 <= r_res_hum;  end
                            default: begin r_tx_data <= 8'h07; r_resp1 <= 8'h00;     end
                        endcase
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_SEND0: r_state <= S_WAIT_TX0;
                S_WAIT_TX0: begin
                    if (i_Tx_Done) begin
                        r_tx_data  <= r_resp1;
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND1;
                    end
                end
                S_SEND1: r_state <= S_WAIT_TX1;
                S_WAIT_TX1: begin
                    if (i_Tx_Done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
